// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with pending-register scoreboard and writeback forwarding
module operand_fetch #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  input  logic [AW-1:0]     dst,
  input  logic              dst_en,
  output logic [AW-1:0]     reg1,
  output logic [AW-1:0]     reg2,
  input  logic [DW-1:0]     data1,
  input  logic [DW-1:0]     data2,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_reg,
  input  logic [DW-1:0]     wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     op1,
  output logic [DW-1:0]     op2,
  output logic [AW-1:0]     out_dst,
  output logic              out_dst_en,
  output logic [2**AW-1:0]  pending
);

  localparam int NR = 2**AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_reg1;
  logic [AW-1:0] r_reg2;
  logic [AW-1:0] r_dst;
  logic          r_dst_en;
  logic [DW-1:0] r_op1;
  logic [DW-1:0] r_op2;
  logic [NR-1:0] r_pending;

  logic          w_fwd1;
  logic          w_fwd2;
  logic          w_blk1;
  logic          w_blk2;
  logic [NR-1:0] w_clr;
  logic [NR-1:0] w_set;

  // A writeback landing this cycle satisfies a pending operand directly.
  assign w_fwd1 = wb_en && (wb_reg == r_reg1);
  assign w_fwd2 = wb_en && (wb_reg == r_reg2);
  assign w_blk1 = r_pending[r_reg1] && !w_fwd1;
  assign w_blk2 = r_pending[r_reg2] && !w_fwd2;

  assign w_clr = wb_en ? (NR'(1) << wb_reg) : '0;
  assign w_set = (r_state == HOLD && out_ready && r_dst_en) ? (NR'(1) << r_dst) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_dst     <= '0;
      r_dst_en  <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_pending <= '0;
    end else begin
      // OR-ing the set after the clear lets the departing instruction's claim win.
      r_pending <= (r_pending & ~w_clr) | w_set;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_reg1   <= src1;
            r_reg2   <= src2;
            r_dst    <= dst;
            r_dst_en <= dst_en;
            r_state  <= READ;
          end
        end
        READ: begin
          if (!w_blk1 && !w_blk2) begin
            r_op1   <= w_fwd1 ? wb_data : data1;
            r_op2   <= w_fwd2 ? wb_data : data2;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_fwd1) r_op1 <= wb_data;
          if (w_fwd2) r_op2 <= wb_data;
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == HOLD);
  assign reg1       = r_reg1;
  assign reg2       = r_reg2;
  assign op1        = r_op1;
  assign op2        = r_op2;
  assign out_dst    = r_dst;
  assign out_dst_en = r_dst_en;
  assign pending    = r_pending;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameters: DW, 8, data width; AW, 2, register address width (2**AW registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  decoder offers an instruction.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 src1, src2  input  AW  source register numbers.
REQ-007 dst  input  AW  destination register number; dst_en  input  1  instruction writes dst.
REQ-008 reg1, reg2  output  AW  register-file read addresses (registered).
REQ-009 data1, data2  input  DW  register-file read data, combinational from reg1/reg2.
REQ-010 wb_en  input  1  writeback this cycle; wb_reg  input  AW; wb_data  input  DW.
REQ-011 out_valid  output  1  operand bundle valid; out_ready  input  1  consumer accepts.
REQ-012 op1, op2  output  DW  fetched operands; out_dst  output  AW; out_dst_en  output  1.
REQ-013 pending  output  2**AW  scoreboard, bit i = register i awaiting writeback.

Function
REQ-014 SHALL implement FSM states IDLE, READ, HOLD.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid latch src1->reg1, src2->reg2, dst, dst_en; next READ.
REQ-016 READ: in_ready=0, out_valid=0; operand k is "blocked" when pending[regk]=1 and not (wb_en and wb_reg==regk).
REQ-017 READ, no operand blocked: capture op1/op2 at clock edge, next HOLD; total accept-to-out_valid latency 2 cycles.
REQ-018 Capture source per operand: wb_data when wb_en and wb_reg==regk, else datak (forwarding priority over register file).
REQ-019 READ, any operand blocked: remain READ, capture nothing; retry every cycle with no bound.
REQ-020 HOLD: out_valid=1, in_ready=0; op1/op2/out_dst/out_dst_en stable except per REQ-021.
REQ-021 HOLD: wb_en with wb_reg==reg1 (reg2) SHALL overwrite op1 (op2) with wb_data at that edge; reg1==reg2 updates both.
REQ-022 HOLD with out_ready=1: handoff at edge; next IDLE; no new instruction accepted in the handoff cycle.
REQ-023 Handoff with out_dst_en=1 SHALL set pending[out_dst].
REQ-024 wb_en SHALL clear pending[wb_reg] in any state.
REQ-025 Same-edge set and clear of one bit: set wins (newer instruction's claim).
REQ-026 Instruction with src==dst SHALL not stall on itself (pending set only at handoff).
REQ-027 wb_en to a register that is not pending SHALL be legal: clears nothing, still forwards per REQ-018/021.
REQ-028 in_valid in READ/HOLD SHALL be ignored; decoder holds it until in_ready.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, reg1=reg2=0, op1=op2=0, out_dst=0, out_dst_en=0, pending=0.
REQ-030 Reset mid-READ or mid-HOLD SHALL discard the instruction without setting any pending bit.
REQ-031 First accept allowed on the first rising edge after reset deasserts.

Verification
REQ-032 RF r1=0xAA, r2=0x55; accept src1=1, src2=2, dst=3, dst_en=1 -> out_valid 2 cycles later, op1=0xAA, op2=0x55; after out_ready handoff pending=4'b1000.
REQ-033 pending[1]=1; accept src1=1 -> stays READ; 3 cycles later wb_en, wb_reg=1, wb_data=0xCC -> HOLD with op1=0xCC, pending[1]=0.
REQ-034 In HOLD op2 from r2, out_ready=0; wb_en wb_reg=2 wb_data=0x11 -> op2=0x11 next cycle, op1 unchanged.
REQ-035 Handoff with out_dst=0 while wb_en wb_reg=0 same cycle -> pending[0]=1.
REQ-036 src1=src2=dst=3, pending=0 -> no stall, op1=op2=r3, pending[3]=1 after handoff.
REQ-037 Assert reset during HOLD -> out_valid=0 and pending=0 same cycle, in_ready=1.
